// File: rtl/rs_pkg.sv
// Shared constants and types for the RS(18,16) decoder over GF(2^8).
package rs_pkg;

  localparam int N            = 18;
  localparam int K            = 16;
  localparam int T            = 1;
  localparam int SYMBOL_WIDTH = 8;
  localparam int CW_WIDTH     = N * SYMBOL_WIDTH;
  localparam int IDX_WIDTH    = $clog2(N);

  typedef logic [SYMBOL_WIDTH-1:0] symbol_t;

  // First received symbol is the highest-degree coefficient, so it lands at the top slot.
  function automatic logic [IDX_WIDTH-1:0] sym_pos(input logic [IDX_WIDTH-1:0] idx);
    return IDX_WIDTH'(N - 1) - idx;
  endfunction

endpackage

// File: rtl/rs_cw_bank.sv
// One N-symbol codeword register bank: indexed symbol write, flat vector read.
module rs_cw_bank
  import rs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IDX_WIDTH-1:0] wr_pos,
  input  symbol_t              wr_data,
  output logic [CW_WIDTH-1:0]  cw_vec
);

  symbol_t sym_q [N];

  // Write the addressed symbol slot; contents persist until overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N; j++) sym_q[j] <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (wr_en && (wr_pos == IDX_WIDTH'(j))) sym_q[j] <= wr_data;
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_flat
    assign cw_vec[j*SYMBOL_WIDTH +: SYMBOL_WIDTH] = sym_q[j];
  end

endmodule

// File: rtl/rs_codeword_collector.sv
// Serial-to-parallel codeword collector with a ping-pong double buffer feeding
// the syndrome stage through a valid/ready handshake.
// Optional build macro: FRAME_CHECK_EN enables in_last framing checks and frame_err.
module rs_codeword_collector
  import rs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_symbol,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  output logic [CW_WIDTH-1:0] cw_data,
  output logic                cw_valid,
  input  logic                cw_ready,
  output logic                frame_err
);

  logic [IDX_WIDTH-1:0] idx;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [1:0]           full;
  logic [1:0]           full_nxt;

  logic                 accept;
  logic                 last_beat;
  logic                 complete;
  logic                 wrap;
  logic                 release_cw;
  logic [IDX_WIDTH-1:0] wr_pos;
  logic [CW_WIDTH-1:0]  bank0_vec;
  logic [CW_WIDTH-1:0]  bank1_vec;

  assign accept     = in_valid & in_ready;
  assign last_beat  = (idx == IDX_WIDTH'(N - 1));
  assign release_cw = cw_valid & cw_ready;
  assign wr_pos     = sym_pos(idx);

`ifdef FRAME_CHECK_EN
  logic frame_bad;
  logic frame_err_q;

  // A codeword counts only when the count and the in_last marker agree.
  assign complete  = accept & last_beat & in_last;
  assign frame_bad = accept & (last_beat ^ in_last);
  assign wrap      = accept & (last_beat | in_last);

  // One-cycle pulse following a framing violation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= frame_bad;
  end

  assign frame_err = frame_err_q;
`else
  logic unused_in_last;

  assign unused_in_last = in_last;
  assign complete       = accept & last_beat;
  assign wrap           = complete;
  assign frame_err      = 1'b0;
`endif

  // Fill and release may both land in the same cycle; they always touch different banks.
  always_comb begin
    full_nxt = full;
    if (release_cw) full_nxt[rd_bank] = 1'b0;
    if (complete)   full_nxt[wr_bank] = 1'b1;
  end

  // Symbol index, bank pointers and occupancy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      if (wrap) begin
        idx <= '0;
        if (complete) wr_bank <= ~wr_bank;
      end else if (accept) begin
        idx <= idx + 1'b1;
      end
      if (release_cw) rd_bank <= ~rd_bank;
      full <= full_nxt;
    end
  end

  rs_cw_bank u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept & ~wr_bank),
    .wr_pos  (wr_pos),
    .wr_data (in_symbol),
    .cw_vec  (bank0_vec)
  );

  rs_cw_bank u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept & wr_bank),
    .wr_pos  (wr_pos),
    .wr_data (in_symbol),
    .cw_vec  (bank1_vec)
  );

  assign in_ready = ~full[wr_bank];
  assign cw_valid = full[rd_bank];
  assign cw_data  = rd_bank ? bank1_vec : bank0_vec;

endmodule

// File: tb/tb_rs_codeword_collector.sv
// Directed bench for rs_codeword_collector; build with or without FRAME_CHECK_EN.
module tb_rs_codeword_collector;

  localparam int N  = 18;
  localparam int CW = 144;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_symbol = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [CW-1:0] cw_data;
  logic          cw_valid;
  logic          cw_ready = 1'b0;
  logic          frame_err;

  int checks = 0;
  int failures = 0;
  int frame_cnt = 0;
  logic [CW-1:0] q [$];

  rs_codeword_collector dut (
    .clk       (clk),
    .rst       (rst),
    .in_symbol (in_symbol),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .cw_data   (cw_data),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Records every handshake-completed codeword and every frame_err pulse.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (cw_valid && cw_ready) q.push_back(cw_data);
      if (frame_err) frame_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Symbol i is b0+i for i<n0, then b1+(i-n0); first symbol at the top byte.
  function automatic logic [CW-1:0] pack_split(input int b0, input int n0, input int b1);
    logic [CW-1:0] v;
    int s;
    v = '0;
    for (int i = 0; i < N; i++) begin
      s = (i < n0) ? (b0 + i) : (b1 + i - n0);
      v[(N-1-i)*8 +: 8] = 8'(s);
    end
    return v;
  endfunction

  task automatic put(input int sym, input logic last);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      in_valid = 1'b0;
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("put_timeout", 1'b0, 1'b1);
    end else begin
      in_valid  = 1'b1;
      in_symbol = 8'(sym);
      in_last   = last;
    end
  endtask

  task automatic put_cw(input int base);
    for (int i = 0; i < N; i++) put(base + i, i == N - 1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int t;
    t = 0;
    while (q.size() < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("q_size", CW'(q.size()), CW'(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    frame_cnt = 0;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_in_ready", CW'(in_ready), CW'(1));
    chk("rst_cw_valid", CW'(cw_valid), CW'(0));
    chk("rst_cw_data", cw_data, '0);
    chk("rst_frame_err", CW'(frame_err), CW'(0));
    rst = 1'b0;

    // 1: single codeword, consumer always ready
    cw_ready = 1'b1;
    put_cw(8'h01);
    idle();
    chk("s1_valid", CW'(cw_valid), CW'(1));
    chk("s1_data", cw_data, pack_split(8'h01, N, 0));
    @(negedge clk);
    chk("s1_valid_drop", CW'(cw_valid), CW'(0));
    chk("s1_q_size", CW'(q.size()), CW'(1));
    if (q.size() > 0) chk("s1_q0", q[0], pack_split(8'h01, N, 0));

    // 2: back-pressure, both banks fill, then drain in order
    q.delete();
    cw_ready = 1'b0;
    put_cw(8'h20);
    put_cw(8'h40);
    idle();
    chk("s2_ready_low", CW'(in_ready), CW'(0));
    chk("s2_hold_valid", CW'(cw_valid), CW'(1));
    chk("s2_hold_data", cw_data, pack_split(8'h20, N, 0));
    repeat (3) @(negedge clk);
    chk("s2_hold_stable", cw_data, pack_split(8'h20, N, 0));
    cw_ready = 1'b1;
    @(negedge clk);
    chk("s2_ready_back", CW'(in_ready), CW'(1));
    chk("s2_second_data", cw_data, pack_split(8'h40, N, 0));
    put_cw(8'h60);
    idle();
    wait_q(3);
    if (q.size() >= 3) begin
      chk("s2_order0", q[0], pack_split(8'h20, N, 0));
      chk("s2_order1", q[1], pack_split(8'h40, N, 0));
      chk("s2_order2", q[2], pack_split(8'h60, N, 0));
    end

    // 3: release coincides with the final symbol of the second bank
    @(negedge clk);
    q.delete();
    cw_ready = 1'b0;
    put_cw(8'h80);
    for (int i = 0; i < N - 1; i++) put(8'hA0 + i, 1'b0);
    put(8'hA0 + N - 1, 1'b1);
    cw_ready = 1'b1;
    @(negedge clk);
    cw_ready = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("s3_ready_kept", CW'(in_ready), CW'(1));
    chk("s3_valid", CW'(cw_valid), CW'(1));
    chk("s3_data_b", cw_data, pack_split(8'hA0, N, 0));
    chk("s3_q_size", CW'(q.size()), CW'(1));
    if (q.size() > 0) chk("s3_q0", q[0], pack_split(8'h80, N, 0));
    cw_ready = 1'b1;
    @(negedge clk);
    chk("s3_drained", CW'(cw_valid), CW'(0));
    chk("s3_no_frame_err", CW'(frame_cnt), CW'(0));

    // 4: asynchronous reset with a held codeword and a partial one
    q.delete();
    cw_ready = 1'b0;
    put_cw(8'h10);
    for (int i = 0; i < 7; i++) put(8'hB0 + i, 1'b0);
    chk("s4_pre_valid", CW'(cw_valid), CW'(1));
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("s4_in_ready", CW'(in_ready), CW'(1));
    chk("s4_cw_valid", CW'(cw_valid), CW'(0));
    chk("s4_cw_data", cw_data, '0);
    chk("s4_frame_err", CW'(frame_err), CW'(0));
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    frame_cnt = 0;
    cw_ready = 1'b1;
    put_cw(8'hC0);
    idle();
    wait_q(1);
    if (q.size() > 0) chk("s4_clean_cw", q[0], pack_split(8'hC0, N, 0));

    // 5: early in_last on the 10th symbol
    do_reset();
    cw_ready = 1'b1;
    for (int i = 0; i < 10; i++) put(8'h30 + i, i == 9);
    idle();
`ifdef FRAME_CHECK_EN
    chk("s5_frame_err", CW'(frame_err), CW'(1));
`else
    chk("s5_frame_err", CW'(frame_err), CW'(0));
`endif
    chk("s5_no_valid", CW'(cw_valid), CW'(0));
    put_cw(8'h50);
    idle();
    wait_q(1);
`ifdef FRAME_CHECK_EN
    if (q.size() > 0) chk("s5_cw", q[0], pack_split(8'h50, N, 0));
    chk("s5_err_count", CW'(frame_cnt), CW'(1));
    // Missing in_last on the 18th symbol drops the codeword
    for (int i = 0; i < N; i++) put(8'h70 + i, 1'b0);
    idle();
    chk("s5_missing_last", CW'(frame_err), CW'(1));
    repeat (3) @(negedge clk);
    chk("s5_dropped", CW'(q.size()), CW'(1));
`else
    if (q.size() > 0) chk("s5_cw", q[0], pack_split(8'h30, 10, 8'h50));
    chk("s5_err_count", CW'(frame_cnt), CW'(0));
`endif

    // 6: in_valid on alternate cycles
    do_reset();
    cw_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      put(8'h01 + i, i == N - 1);
      idle();
    end
    wait_q(1);
    if (q.size() > 0) chk("s6_cw", q[0], pack_split(8'h01, N, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
